// File: rtl/iq_sample_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iq_sample_streamer_pkg
// Description : Register map, CTRL bit positions and midscale helper shared
//               by the I/Q sample streamer and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package iq_sample_streamer_pkg;

    // hbbus page this block decodes to (upper address bits)
    localparam logic [21:0] c_page_addr = 22'h084;

    // Register select values on i_wb_addr
    localparam logic [1:0] c_addr_ctrl = 2'd0;
    localparam logic [1:0] c_addr_rate = 2'd1;
    localparam logic [1:0] c_addr_data = 2'd2;
    localparam logic [1:0] c_addr_ucnt = 2'd3;

    // CTRL register bit positions
    localparam int c_ctrl_enable     = 0;
    localparam int c_ctrl_flush      = 1;
    localparam int c_ctrl_clear      = 2;
    localparam int c_ctrl_thresh_lsb = 16;

    // DATA write packing: I in the upper half-word, Q in the lower one
    localparam int c_data_i_lsb = 16;
    localparam int c_data_q_lsb = 0;

    // Offset-binary zero for a DAC of the given width
    function automatic logic [31:0] midscale_of(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iq_sample_streamer_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous first-word-fall-through FIFO holding packed
//               {I,Q} words, with single-cycle flush and a fill-level count.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int WIDTH      = 20,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  logic [WIDTH-1:0]      i_wr_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic [WIDTH-1:0]      o_rd_data
);

    localparam logic [ADDR_WIDTH:0] c_depth = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [WIDTH-1:0]      r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  w_do_push;
    logic                  w_do_pop;

    // Flush overrides both ports; full/empty are judged before this cycle's ops
    assign w_do_push = i_push && !o_full  && !i_flush;
    assign w_do_pop  = i_pop  && !o_empty && !i_flush;

    assign o_full    = (r_level == c_depth);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Storage array: written only on an accepted push, never reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers and fill level
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/iq_sample_streamer.sv
`default_nettype none
// ============================================================================
// Module      : iq_sample_streamer
// Description : Wishbone-fed I/Q sample FIFO released at a programmable rate
//               to the modulator, with underrun/overflow accounting and a
//               low-water interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_sample_streamer
    import iq_sample_streamer_pkg::*;
#(
    parameter int OUTPUT_DAC_WIDTH = 10,
    parameter int FIFO_ADDR_WIDTH  = 6,
    parameter int RATE_WIDTH       = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_wb_cyc,
    input  logic                        i_wb_stb,
    input  logic                        i_wb_we,
    input  logic [1:0]                  i_wb_addr,
    input  logic [31:0]                 i_wb_data,
    output logic                        o_wb_ack,
    output logic                        o_wb_stall,
    output logic [31:0]                 o_wb_data,
    output logic [OUTPUT_DAC_WIDTH-1:0] o_sample_i,
    output logic [OUTPUT_DAC_WIDTH-1:0] o_sample_q,
    output logic                        o_sample_stb,
    output logic                        o_interrupt
);

    localparam int c_fifo_width = 2 * OUTPUT_DAC_WIDTH;
    localparam logic [31:0] c_mid32 = midscale_of(OUTPUT_DAC_WIDTH);
    localparam logic [OUTPUT_DAC_WIDTH-1:0] c_mid = c_mid32[OUTPUT_DAC_WIDTH-1:0];

    logic                        r_enable;
    logic                        r_flush;
    logic [FIFO_ADDR_WIDTH-1:0]  r_thresh;
    logic [RATE_WIDTH-1:0]       r_rate;
    logic [RATE_WIDTH-1:0]       r_cnt;
    logic                        r_overflow;
    logic                        r_underrun;
    logic [15:0]                 r_ucnt;

    logic                        w_wr;
    logic                        w_wr_ctrl;
    logic                        w_wr_rate;
    logic                        w_wr_data;
    logic                        w_clear;
    logic                        w_tick;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_ovf_event;
    logic                        w_unf_event;
    logic                        w_full;
    logic                        w_empty;
    logic [FIFO_ADDR_WIDTH:0]    w_level;
    logic [c_fifo_width-1:0]     w_wr_word;
    logic [c_fifo_width-1:0]     w_rd_word;
    logic [31:0]                 w_rd_data;
    logic                        w_unused;

    assign o_wb_stall = 1'b0;
    assign w_unused   = &{1'b0, i_wb_data[31:26]};

    assign w_wr      = i_wb_cyc && i_wb_stb && i_wb_we;
    assign w_wr_ctrl = w_wr && (i_wb_addr == c_addr_ctrl);
    assign w_wr_rate = w_wr && (i_wb_addr == c_addr_rate);
    assign w_wr_data = w_wr && (i_wb_addr == c_addr_data);
    assign w_clear   = w_wr_ctrl && i_wb_data[c_ctrl_clear];
    assign w_wr_word = {i_wb_data[c_data_i_lsb +: OUTPUT_DAC_WIDTH],
                        i_wb_data[c_data_q_lsb +: OUTPUT_DAC_WIDTH]};

    // The flush pulse is registered, so it lands on the bus cycle after the
    // CTRL write; a push or pop in that cycle is discarded without flagging.
    assign w_tick      = r_enable && (r_cnt == '0);
    assign w_push      = w_wr_data && !w_full && !r_flush;
    assign w_ovf_event = w_wr_data &&  w_full && !r_flush;
    assign w_pop       = w_tick && !w_empty && !r_flush;
    assign w_unf_event = w_tick &&  w_empty;

    sample_fifo #(
        .WIDTH      (c_fifo_width),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (r_flush),
        .i_wr_data (w_wr_word),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level),
        .o_rd_data (w_rd_word)
    );

    // Read-data mux; self-clearing CTRL bits always read back as zero
    always_comb begin
        w_rd_data = '0;
        case (i_wb_addr)
            c_addr_ctrl: begin
                w_rd_data[c_ctrl_enable] = r_enable;
                w_rd_data[c_ctrl_thresh_lsb +: FIFO_ADDR_WIDTH] = r_thresh;
            end
            c_addr_rate: w_rd_data[RATE_WIDTH-1:0] = r_rate;
            c_addr_data: begin
                w_rd_data[31] = r_overflow;
                w_rd_data[30] = r_underrun;
                w_rd_data[FIFO_ADDR_WIDTH:0] = w_level;
            end
            default:     w_rd_data[15:0] = r_ucnt;
        endcase
    end

    // Bus response: one ack per strobe, read data captured on the same edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack <= i_wb_stb;
            if (i_wb_stb) begin
                o_wb_data <= w_rd_data;
            end
        end
    end

    // Control and rate registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_enable <= 1'b0;
            r_flush  <= 1'b0;
            r_thresh <= '0;
            r_rate   <= '0;
        end else begin
            r_flush <= w_wr_ctrl && i_wb_data[c_ctrl_flush];
            if (w_wr_ctrl) begin
                r_enable <= i_wb_data[c_ctrl_enable];
                r_thresh <= i_wb_data[c_ctrl_thresh_lsb +: FIFO_ADDR_WIDTH];
            end
            if (w_wr_rate) begin
                r_rate <= i_wb_data[RATE_WIDTH-1:0];
            end
        end
    end

    // Sample-rate down-counter: held at RATE while idle, reloads on each tick
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (!r_enable || (r_cnt == '0)) begin
            r_cnt <= r_rate;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Sample output: popped word or midscale one cycle after each tick
    always_ff @(posedge i_clk) begin
        if (i_reset || !r_enable) begin
            o_sample_i   <= c_mid;
            o_sample_q   <= c_mid;
            o_sample_stb <= 1'b0;
        end else if (w_tick) begin
            o_sample_stb <= 1'b1;
            if (w_pop) begin
                o_sample_i <= w_rd_word[c_fifo_width-1:OUTPUT_DAC_WIDTH];
                o_sample_q <= w_rd_word[OUTPUT_DAC_WIDTH-1:0];
            end else begin
                o_sample_i <= c_mid;
                o_sample_q <= c_mid;
            end
        end else begin
            o_sample_stb <= 1'b0;
        end
    end

    // Sticky flags and saturating underrun counter; a new event beats clear
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
            r_ucnt     <= '0;
        end else begin
            if (w_ovf_event) begin
                r_overflow <= 1'b1;
            end else if (w_clear) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_event) begin
                r_underrun <= 1'b1;
            end else if (w_clear) begin
                r_underrun <= 1'b0;
            end
            if (w_clear) begin
                r_ucnt <= w_unf_event ? 16'd1 : 16'd0;
            end else if (w_unf_event && (r_ucnt != 16'hFFFF)) begin
                r_ucnt <= r_ucnt + 16'd1;
            end
        end
    end

    // Low-water interrupt level
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_interrupt <= 1'b0;
        end else begin
            o_interrupt <= r_enable && (w_level <= {1'b0, r_thresh});
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iq_sample_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_sample_streamer
// Description : Self-checking bench for iq_sample_streamer; a queue model of
//               the FIFO predicts emitted samples, flags and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_sample_streamer;

    localparam logic [1:0]  A_CTRL = 2'd0;
    localparam logic [1:0]  A_RATE = 2'd1;
    localparam logic [1:0]  A_DATA = 2'd2;
    localparam logic [1:0]  A_UCNT = 2'd3;
    localparam logic [19:0] MID    = {10'h200, 10'h200};

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [1:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic        wb_ack, wb_stall;
    logic [31:0] wb_rdata;
    logic [9:0]  sample_i, sample_q;
    logic        sample_stb, irq;

    int tests = 0;
    int fails = 0;
    int cycle_cnt = 0;

    int          cap_t[$];
    logic [19:0] cap_w[$];

    always #5 clk = ~clk;

    iq_sample_streamer dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_wb_cyc     (wb_cyc),
        .i_wb_stb     (wb_stb),
        .i_wb_we      (wb_we),
        .i_wb_addr    (wb_addr),
        .i_wb_data    (wb_wdata),
        .o_wb_ack     (wb_ack),
        .o_wb_stall   (wb_stall),
        .o_wb_data    (wb_rdata),
        .o_sample_i   (sample_i),
        .o_sample_q   (sample_q),
        .o_sample_stb (sample_stb),
        .o_interrupt  (irq)
    );

    always @(posedge clk) cycle_cnt++;

    // Record every presented sample with its cycle number
    always @(negedge clk) begin
        if (sample_stb) begin
            cap_t.push_back(cycle_cnt);
            cap_w.push_back({sample_i, sample_q});
        end
    end

    function automatic logic [31:0] pack(input logic [9:0] i, input logic [9:0] q);
        return {6'b0, i, 6'b0, q};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = d;
        @(posedge clk); #1;
        tests++;
        if (wb_ack !== 1'b1) begin
            fails++;
            $display("FAIL wr_ack addr=%0d got=%b want=1", a, wb_ack);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = a;
        @(posedge clk); #1;
        tests++;
        if (wb_ack !== 1'b1) begin
            fails++;
            $display("FAIL rd_ack addr=%0d got=%b want=1", a, wb_ack);
        end
        d = wb_rdata;
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        cap_t.delete();
        cap_w.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        idle(3);
        tests++;
        if (sample_i !== 10'h200 || sample_q !== 10'h200) begin
            fails++;
            $display("FAIL reset_samples got=%h/%h want=200/200", sample_i, sample_q);
        end
        tests++;
        if (sample_stb !== 1'b0 || irq !== 1'b0 || wb_ack !== 1'b0 || wb_stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl_outs got stb=%b irq=%b ack=%b stall=%b want 0", sample_stb, irq, wb_ack, wb_stall);
        end
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            wb_read(2'(a), d);
            tests++;
            if (d !== 32'h0) begin
                fails++;
                $display("FAIL reset_reg%0d got=%h want=00000000", a, d);
            end
        end
    endtask

    task automatic test_rate_order();
        logic [31:0] d;
        int n;
        apply_reset();
        wb_write(A_RATE, 32'd3);
        wb_write(A_DATA, pack(10'h3FF, 10'h000));
        wb_write(A_DATA, pack(10'h155, 10'h2AA));
        cap_t.delete(); cap_w.delete();
        wb_write(A_CTRL, 32'h1);
        idle(18);
        wb_write(A_CTRL, 32'h0);
        idle(3);
        n = cap_w.size();
        tests++;
        if (n < 3) begin
            fails++;
            $display("FAIL rate_count got=%0d want>=3", n);
        end
        tests++;
        if (cap_w[0] !== {10'h3FF, 10'h000} || cap_w[1] !== {10'h155, 10'h2AA} || cap_w[2] !== MID) begin
            fails++;
            $display("FAIL rate_order got=%h,%h,%h want=ffc00,556aa,80200", cap_w[0], cap_w[1], cap_w[2]);
        end
        for (int k = 1; k < n; k++) begin
            tests++;
            if (cap_t[k] - cap_t[k-1] !== 4) begin
                fails++;
                $display("FAIL rate_gap%0d got=%0d want=4", k, cap_t[k] - cap_t[k-1]);
            end
        end
        tests++;
        if (sample_stb !== 1'b0 || sample_i !== 10'h200 || sample_q !== 10'h200) begin
            fails++;
            $display("FAIL disable_idle got stb=%b %h/%h want 0 200/200", sample_stb, sample_i, sample_q);
        end
        wb_read(A_DATA, d);
        tests++;
        if (d !== 32'h4000_0000) begin
            fails++;
            $display("FAIL rate_status got=%h want=40000000", d);
        end
        wb_read(A_UCNT, d);
        tests++;
        if (d !== 32'(n - 2)) begin
            fails++;
            $display("FAIL rate_ucnt got=%0d want=%0d", d, n - 2);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [19:0] q[$];
        logic [19:0] w;
        apply_reset();
        for (int k = 0; k < 65; k++) begin
            w = 20'($urandom);
            wb_write(A_DATA, pack(w[19:10], w[9:0]));
            if (q.size() < 64) q.push_back(w);
        end
        wb_read(A_DATA, d);
        tests++;
        if (d !== 32'h8000_0040) begin
            fails++;
            $display("FAIL ovf_status got=%h want=80000040", d);
        end
        cap_t.delete(); cap_w.delete();
        wb_write(A_CTRL, 32'h1);
        idle(70);
        wb_write(A_CTRL, 32'h0);
        idle(3);
        tests++;
        if (cap_w.size() < 65) begin
            fails++;
            $display("FAIL ovf_drain_count got=%0d want>=65", cap_w.size());
        end
        for (int k = 0; k < 64; k++) begin
            tests++;
            if (cap_w[k] !== q[k]) begin
                fails++;
                $display("FAIL ovf_word%0d got=%h want=%h", k, cap_w[k], q[k]);
            end
        end
        tests++;
        if (cap_w[64] !== MID) begin
            fails++;
            $display("FAIL ovf_65th got=%h want=%h", cap_w[64], MID);
        end
        wb_write(A_CTRL, 32'h4);
        wb_read(A_DATA, d);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL clear_status got=%h want=00000000", d);
        end
        wb_read(A_UCNT, d);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL clear_ucnt got=%h want=00000000", d);
        end
    endtask

    task automatic test_interrupt();
        logic [31:0] d;
        int lvl;
        logic exp;
        apply_reset();
        wb_write(A_CTRL, 32'h0004_0000);
        for (int k = 0; k < 6; k++) wb_write(A_DATA, 32'($urandom) & 32'h03FF_03FF);
        wb_write(A_RATE, 32'd0);
        wb_write(A_CTRL, 32'h0004_0001);
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_at_enable got=%b want=0", irq);
        end
        // One pop per cycle from 6; the level seen before each edge drives irq
        lvl = 6;
        for (int k = 1; k <= 8; k++) begin
            exp = (lvl <= 4);
            idle(1);
            tests++;
            if (irq !== exp) begin
                fails++;
                $display("FAIL irq_cycle%0d got=%b want=%b", k, irq, exp);
            end
            if (lvl > 0) lvl--;
        end
        wb_read(A_CTRL, d);
        tests++;
        if (d !== 32'h0004_0001) begin
            fails++;
            $display("FAIL irq_ctrl_rb got=%h want=00040001", d);
        end
        wb_write(A_CTRL, 32'h0);
    endtask

    task automatic test_back_to_back_flush();
        logic [31:0] d;
        apply_reset();
        for (int k = 0; k < 3; k++) wb_write(A_DATA, 32'($urandom) & 32'h03FF_03FF);
        wb_write(A_CTRL, 32'h2);
        wb_write(A_DATA, pack(10'h123, 10'h321));
        wb_read(A_DATA, d);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL flush_status got=%h want=00000000", d);
        end
        wb_read(A_CTRL, d);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL flush_ctrl_rb got=%h want=00000000", d);
        end
        wb_write(A_DATA, pack(10'h0AB, 10'h0CD));
        wb_read(A_DATA, d);
        tests++;
        if (d !== 32'h1) begin
            fails++;
            $display("FAIL post_flush_level got=%h want=00000001", d);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] d;
        apply_reset();
        wb_write(A_RATE, 32'd1);
        for (int k = 0; k < 10; k++) wb_write(A_DATA, 32'($urandom) & 32'h03FF_03FF);
        wb_write(A_CTRL, 32'h1);
        idle(5);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = A_DATA;
        rst = 1'b1;
        idle(1);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tests++;
        if (wb_ack !== 1'b0 || sample_stb !== 1'b0) begin
            fails++;
            $display("FAIL midrst_ack_stb got ack=%b stb=%b want 0 0", wb_ack, sample_stb);
        end
        tests++;
        if (sample_i !== 10'h200 || sample_q !== 10'h200) begin
            fails++;
            $display("FAIL midrst_samples got=%h/%h want=200/200", sample_i, sample_q);
        end
        rst = 1'b0;
        cap_t.delete(); cap_w.delete();
        idle(5);
        tests++;
        if (cap_w.size() != 0) begin
            fails++;
            $display("FAIL midrst_quiet got=%0d strobes want=0", cap_w.size());
        end
        wb_read(A_DATA, d);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL midrst_status got=%h want=00000000", d);
        end
        wb_read(A_RATE, d);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL midrst_rate got=%h want=00000000", d);
        end
    endtask

    task automatic test_random_stream();
        logic [31:0] d;
        logic [19:0] q[$];
        logic [19:0] w;
        int rate, n, m;
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            q.delete();
            rate = $urandom_range(0, 5);
            n    = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                w = 20'($urandom);
                wb_write(A_DATA, pack(w[19:10], w[9:0]));
                q.push_back(w);
            end
            wb_write(A_RATE, 32'(rate));
            cap_t.delete(); cap_w.delete();
            wb_write(A_CTRL, 32'h1);
            idle((n + 3) * (rate + 1) + 4);
            wb_write(A_CTRL, 32'h0);
            idle(3);
            m = cap_w.size();
            tests++;
            if (m <= n) begin
                fails++;
                $display("FAIL rnd%0d_count got=%0d want>%0d", it, m, n);
            end
            for (int k = 0; k < m; k++) begin
                w = (k < n) ? q[k] : MID;
                tests++;
                if (cap_w[k] !== w) begin
                    fails++;
                    $display("FAIL rnd%0d_word%0d got=%h want=%h", it, k, cap_w[k], w);
                end
                if (k > 0) begin
                    tests++;
                    if (cap_t[k] - cap_t[k-1] !== rate + 1) begin
                        fails++;
                        $display("FAIL rnd%0d_gap%0d got=%0d want=%0d", it, k, cap_t[k] - cap_t[k-1], rate + 1);
                    end
                end
            end
            wb_read(A_UCNT, d);
            tests++;
            if (d !== 32'(m - n)) begin
                fails++;
                $display("FAIL rnd%0d_ucnt got=%0d want=%0d", it, d, m - n);
            end
            wb_read(A_DATA, d);
            tests++;
            if (d !== 32'h4000_0000) begin
                fails++;
                $display("FAIL rnd%0d_status got=%h want=40000000", it, d);
            end
        end
    endtask

    initial begin
        rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_addr = 2'd0; wb_wdata = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_rate_order();
        test_overflow();
        test_interrupt();
        test_back_to_back_flush();
        test_mid_reset();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
